// File: rtl/fifo_stream_reader_pkg.sv
// Shared types, buffer depth and the issue-credit rule for the FIFO stream reader.
// The credit rule lives here so that the bench model can call the same function.
package fifo_stream_reader_pkg;

   localparam int unsigned OUT_BUF_DEPTH = 2;

   typedef logic [1:0] occ_t;

   // A new read may issue only if the word it returns will have a buffer slot.
   function automatic logic issue_credit_ok(input int unsigned occ,
                                            input logic        inflight,
                                            input logic        pop);
      int level;
      level = int'(occ) + int'(inflight) - int'(pop);
      return level < int'(OUT_BUF_DEPTH);
   endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read-port and valid/ready stream signals of the FIFO stream reader.
// The reader sits on the master side; the FIFO and the consumer sit on the slave side.
interface fifo_stream_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic                  fifo_r_en;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (
      input  fifo_empty, fifo_data, m_ready,
      output fifo_r_en, m_valid, m_data
   );

   modport slave (
      output fifo_empty, fifo_data, m_ready,
      input  fifo_r_en, m_valid, m_data
   );
endinterface

// File: rtl/fifo_stream_reader_stream_skid_buf2.sv
// Two-entry in-order buffer: push writes the tail, pop drops the head.
// The head register is the stream output, so m_data holds still while no pop occurs.
module stream_skid_buf2
   import fifo_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output occ_t                  occ
);

   logic [DATA_WIDTH-1:0] entry0;
   logic [DATA_WIDTH-1:0] entry1;

   assign head = entry0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry0 <= '0;
         entry1 <= '0;
         occ    <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) entry0 <= din;
               else             entry1 <= din;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               occ    <= occ - 2'd1;
            end
            2'b11: begin
               // Simultaneous push/pop: the new word lands behind whatever remains.
               if (occ == 2'd2) begin
                  entry0 <= entry1;
                  entry1 <= din;
               end else begin
                  entry0 <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine for the synchronous FIFO: issues reads, absorbs the one-cycle
// read latency and presents popped words on a valid/ready stream.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   fifo_stream_reader_if.master      bus,
   output logic [CNT_WIDTH-1:0]      words_out,
   output logic                      busy
);

   logic                  inflight;
   logic                  pop;
   occ_t                  occ;
   logic [DATA_WIDTH-1:0] head;

   assign bus.m_valid = (occ != 2'd0);
   assign bus.m_data  = head;
   assign pop         = bus.m_valid & bus.m_ready;
   assign busy        = inflight | (occ != 2'd0);

   // Gated by rst_n so no read is requested while the reader is held in reset.
   assign bus.fifo_r_en = rst_n & enable & ~bus.fifo_empty
                        & issue_credit_ok(occ, inflight, pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight  <= 1'b0;
         words_out <= '0;
      end else begin
         inflight <= bus.fifo_r_en;
         if (pop) words_out <= words_out + 1'b1;
      end
   end

   stream_skid_buf2 #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_buf (
      .clk  (clk),
      .rst_n(rst_n),
      .push (inflight),
      .din  (bus.fifo_data),
      .pop  (pop),
      .head (head),
      .occ  (occ)
   );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench for fifo_stream_reader against a queue-based model
// of the FIFO, the read latency and the two-word output buffer.
module tb_fifo_stream_reader;
   import fifo_stream_reader_pkg::*;

   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [CW-1:0] words_out;
   logic          busy;

   fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

   fifo_stream_reader #(
      .DATA_WIDTH(DW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .bus      (bus.master),
      .words_out(words_out),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // FIFO contents, and the reference model: words in flight and in the output buffer.
   logic [DW-1:0] fifo_q[$];
   int            fifo_cnt = 0;
   logic [DW-1:0] mbuf[$];
   logic          minfl = 1'b0;
   logic [DW-1:0] mword = '0;
   int            mcount = 0;

   int checks = 0;
   int errors = 0;

   int            cyc = 0;
   int            ren_log[$];
   int            pop_cyc[$];
   logic [DW-1:0] pop_dat[$];

   assign bus.fifo_empty = (fifo_cnt == 0);

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mbuf.delete();
         minfl  = 1'b0;
         mcount = 0;
      end else begin
         logic mpop, mren;
         mpop = (mbuf.size() != 0) && bus.m_ready;
         mren = enable && (fifo_q.size() != 0)
                && issue_credit_ok(mbuf.size(), minfl, mpop);
         if (mpop) begin
            void'(mbuf.pop_front());
            mcount++;
         end
         if (minfl) mbuf.push_back(mword);
         minfl = mren;
         if (mren) mword = fifo_q[0];
         if (bus.fifo_r_en && fifo_q.size() != 0) bus.fifo_data <= fifo_q.pop_front();
         else                                     bus.fifo_data <= DW'($urandom);
         fifo_cnt <= fifo_q.size();
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         logic exp_valid, exp_ren;
         exp_valid = (mbuf.size() != 0);
         exp_ren   = enable && (fifo_q.size() != 0)
                     && issue_credit_ok(mbuf.size(), minfl, exp_valid && bus.m_ready);
         chk("fifo_r_en", bus.fifo_r_en, exp_ren);
         chk("m_valid", bus.m_valid, exp_valid);
         if (exp_valid) chk("m_data", bus.m_data, mbuf[0]);
         chk("words_out", words_out, mcount % (1 << CW));
         chk("busy", busy, minfl || exp_valid);
         if (bus.fifo_empty) chk("r_en_when_empty", bus.fifo_r_en, 0);
         chk("occ_plus_inflight_le_2",
             (int'(dut.u_buf.occ) + int'(dut.inflight)) <= 2, 1);
         if (bus.fifo_r_en) ren_log.push_back(cyc);
         if (bus.m_valid && bus.m_ready) begin
            pop_cyc.push_back(cyc);
            pop_dat.push_back(bus.m_data);
         end
         cyc++;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      ren_log.delete();
      pop_cyc.delete();
      pop_dat.delete();
      cyc = 0;
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      fifo_cnt = fifo_q.size();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_m_valid"}, bus.m_valid, 0);
      chk({tag, "_fifo_r_en"}, bus.fifo_r_en, 0);
      chk({tag, "_words_out"}, words_out, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_m_data"}, bus.m_data, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      enable = 1'b0;
      bus.m_ready = 1'b0;
      bus.fifo_data = '0;
      #2;
      chk_reset_outputs("init_reset");
      step(3);
      rst_n = 1'b1;
      step(1);

      // Continuous stream of 8 words.
      for (int i = 0; i < 8; i++) push_word(DW'(8'h11 + i));
      clear_log();
      enable = 1'b1;
      bus.m_ready = 1'b1;
      step(12);
      chk("stream_ren_cnt", ren_log.size(), 8);
      if (ren_log.size() == 8) begin
         chk("stream_ren_first", ren_log[0], 0);
         chk("stream_ren_last", ren_log[7], 7);
      end
      chk("stream_pop_cnt", pop_dat.size(), 8);
      for (int i = 0; i < pop_dat.size() && i < 8; i++) begin
         chk("stream_data", pop_dat[i], 8'h11 + i);
         chk("stream_cycle", pop_cyc[i], 2 + i);
      end
      chk("stream_words_out", words_out, 8);
      chk("stream_busy", busy, 0);

      // Backpressure: only two reads fit while the consumer stalls.
      bus.m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_word(DW'(8'h11 + i));
      clear_log();
      step(6);
      chk("bp_ren_cnt", ren_log.size(), 2);
      chk("bp_m_valid", bus.m_valid, 1);
      chk("bp_m_data", bus.m_data, 8'h11);
      bus.m_ready = 1'b1;
      clear_log();
      step(8);
      chk("bp_pop_cnt", pop_dat.size(), 4);
      for (int i = 0; i < pop_dat.size() && i < 4; i++) begin
         chk("bp_data", pop_dat[i], 8'h11 + i);
         chk("bp_cycle", pop_cyc[i], i);
      end
      chk("bp_busy", busy, 0);

      // Empty boundary: three words only.
      for (int i = 0; i < 3; i++) push_word(DW'(8'h11 + i));
      clear_log();
      step(8);
      chk("empty_ren_cnt", ren_log.size(), 3);
      chk("empty_pop_cnt", pop_dat.size(), 3);
      for (int i = 0; i < pop_dat.size() && i < 3; i++) begin
         chk("empty_data", pop_dat[i], 8'h11 + i);
         chk("empty_cycle", pop_cyc[i], 2 + i);
      end
      chk("empty_m_valid", bus.m_valid, 0);
      chk("empty_words_out", words_out, 15);

      // Enable drop with a read in flight and a word buffered.
      bus.m_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(DW'(8'h21 + i));
      clear_log();
      step(2);
      chk("drop_busy_before", busy, 1);
      enable = 1'b0;
      step(1);
      bus.m_ready = 1'b1;
      step(5);
      chk("drop_ren_cnt", ren_log.size(), 2);
      chk("drop_pop_cnt", pop_dat.size(), 2);
      if (pop_dat.size() == 2) begin
         chk("drop_data0", pop_dat[0], 8'h21);
         chk("drop_data1", pop_dat[1], 8'h22);
      end
      chk("drop_busy_after", busy, 0);
      chk("drop_words_out", words_out, 1);

      // Async reset with a full buffer; buffered words are discarded.
      enable = 1'b1;
      bus.m_ready = 1'b0;
      step(4);
      chk("rst_full_m_valid", bus.m_valid, 1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid_reset");
      step(1);
      rst_n = 1'b1;
      clear_log();
      bus.m_ready = 1'b1;
      step(5);
      chk("rst_next_pop_cnt", pop_dat.size(), 1);
      if (pop_dat.size() != 0) chk("rst_next_data", pop_dat[0], 8'h25);
      chk("rst_words_out", words_out, 1);

      // Counter wrap: 17 handshakes on a 4-bit counter.
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      for (int i = 0; i < 17; i++) push_word(DW'(8'h40 + i));
      clear_log();
      step(24);
      chk("wrap_pop_cnt", pop_dat.size(), 17);
      chk("wrap_words_out", words_out, 1);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 1500; n++) begin
         enable      = ($urandom % 8) != 0;
         bus.m_ready = ($urandom % 3) != 0;
         if (($urandom % 3) == 0 && fifo_q.size() < 12) push_word(DW'($urandom));
         if (($urandom % 200) == 0) begin
            rst_n = 1'b0;
            step(1);
            rst_n = 1'b1;
         end
         step(1);
      end

      enable = 1'b1;
      bus.m_ready = 1'b1;
      step(40);
      chk("final_busy", busy, 0);
      chk("final_fifo_empty", bus.fifo_empty, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
